// File: rtl/decoder_pkg.sv
// Shared types and widths for the bus region decoder.
package decoder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    localparam int WS_W   = 3;
    localparam int WDOG_W = 8;
endpackage

// File: rtl/region_match.sv
// Combinational address-to-region priority match; lowest matching index wins.
module region_match
    import decoder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter logic [NREG-1:0][ADDR_W-1:0] REG_BASE = '0,
    parameter logic [NREG-1:0][ADDR_W-1:0] REG_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   onehot,
    output logic              hit
);
    always_comb begin
        onehot = '0;
        hit    = 1'b0;
        // Walk from the top so the lowest matching index overwrites last.
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((addr & REG_MASK[i]) == (REG_BASE[i] & REG_MASK[i])) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_region_decoder.sv
// CPU bus region decoder: chip selects, wait-state stretching, strobes and a
// frame-driven watchdog that is kicked by writes to one region.
module bus_region_decoder
    import decoder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter logic [NREG-1:0][ADDR_W-1:0] REG_BASE = '0,
    parameter logic [NREG-1:0][ADDR_W-1:0] REG_MASK = '0,
    parameter logic [NREG-1:0][WS_W-1:0]   REG_WS   = '0,
    parameter int WDOG_IDX   = 1,
    parameter int WDOG_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phi2_en,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic              frame_tick,
    output logic [NREG-1:0]   sel,
    output logic [NREG-1:0]   rd_stb,
    output logic [NREG-1:0]   wr_stb,
    output logic              ready,
    output logic              unmapped,
    output logic              wdog_reset
);
    state_t            state, state_n;
    logic [WS_W-1:0]   wait_cnt, cnt_n;
    logic [NREG-1:0]   hold_sel, hold_sel_n;
    logic              hold_rw, hold_rw_n;
    logic [NREG-1:0]   sel_n, rd_n, wr_n;
    logic              unm_n;
    logic [NREG-1:0]   match_oh;
    logic              match_hit;
    logic [WS_W-1:0]   match_ws;
    logic [WDOG_W-1:0] wdog_cnt;

    region_match #(
        .ADDR_W   (ADDR_W),
        .NREG     (NREG),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_match (
        .addr   (addr),
        .onehot (match_oh),
        .hit    (match_hit)
    );

    always_comb begin
        match_ws = '0;
        for (int i = 0; i < NREG; i++) begin
            if (match_oh[i]) match_ws = REG_WS[i];
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = wait_cnt;
        hold_sel_n = hold_sel;
        hold_rw_n  = hold_rw;
        sel_n      = '0;
        rd_n       = '0;
        wr_n       = '0;
        unm_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (phi2_en && valid) begin
                    if (match_hit) begin
                        hold_sel_n = match_oh;
                        hold_rw_n  = rw;
                        sel_n      = match_oh;
                        if (match_ws == '0) begin
                            state_n = ST_STROBE;
                            rd_n    = rw ? match_oh : '0;
                            wr_n    = rw ? '0 : match_oh;
                        end else begin
                            state_n = ST_WAIT;
                            cnt_n   = match_ws;
                        end
                    end else begin
                        unm_n = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                sel_n = hold_sel;
                cnt_n = wait_cnt - 3'd1;
                // Counter hits zero on this edge: the strobe cycle follows.
                if (wait_cnt == 3'd1) begin
                    state_n = ST_STROBE;
                    rd_n    = hold_rw ? hold_sel : '0;
                    wr_n    = hold_rw ? '0 : hold_sel;
                end
            end
            ST_STROBE: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            hold_sel <= '0;
            hold_rw  <= 1'b1;
            sel      <= '0;
            rd_stb   <= '0;
            wr_stb   <= '0;
            unmapped <= 1'b0;
            ready    <= 1'b1;
        end else begin
            state    <= state_n;
            wait_cnt <= cnt_n;
            hold_sel <= hold_sel_n;
            hold_rw  <= hold_rw_n;
            sel      <= sel_n;
            rd_stb   <= rd_n;
            wr_stb   <= wr_n;
            unmapped <= unm_n;
            ready    <= (state_n != ST_WAIT);
        end
    end

    // A kick in the same clk as a frame tick wins over the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt   <= '0;
            wdog_reset <= 1'b0;
        end else begin
            wdog_reset <= 1'b0;
            if (wr_stb[WDOG_IDX]) begin
                wdog_cnt <= '0;
            end else if (frame_tick) begin
                if (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1)) begin
                    wdog_cnt   <= '0;
                    wdog_reset <= 1'b1;
                end else begin
                    wdog_cnt <= wdog_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_region_decoder.sv
// Self-checking bench for bus_region_decoder: directed scenarios plus random
// accesses checked against a table-driven behavioural model.
module tb_bus_region_decoder;
    import decoder_pkg::*;

    localparam logic [7:0][15:0] TB_BASE = {16'h8000, 16'h6000, 16'h5000, 16'h0000,
                                            16'h3000, 16'h2000, 16'h1000, 16'h0100};
    localparam logic [7:0][15:0] TB_MASK = {16'h8000, 16'hFF00, 16'hF000, 16'hF000,
                                            16'hF000, 16'hF000, 16'hF000, 16'hFF00};
    localparam logic [7:0][2:0]  TB_WS   = {3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd0, 3'd0, 3'd1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phi2_en = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] addr = '0;
    logic        rw = 1'b1;
    logic        frame_tick = 1'b0;
    logic [7:0]  sel, rd_stb, wr_stb;
    logic        ready, unmapped, wdog_reset;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] o_sel [1:10];
    logic [7:0] o_rd  [1:10];
    logic [7:0] o_wr  [1:10];
    logic       o_rdy [1:10];
    logic       o_unm [1:10];

    bus_region_decoder #(
        .ADDR_W(16), .NREG(8), .REG_BASE(TB_BASE), .REG_MASK(TB_MASK), .REG_WS(TB_WS),
        .WDOG_IDX(1), .WDOG_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst), .phi2_en(phi2_en), .valid(valid), .addr(addr), .rw(rw),
        .frame_tick(frame_tick), .sel(sel), .rd_stb(rd_stb), .wr_stb(wr_stb),
        .ready(ready), .unmapped(unmapped), .wdog_reset(wdog_reset)
    );

    always #5 clk = ~clk;

    // Model: first matching table entry, or -1 when nothing matches.
    function automatic int model_region(input logic [15:0] a);
        for (int i = 0; i < 8; i++)
            if ((a & TB_MASK[i]) == (TB_BASE[i] & TB_MASK[i])) return i;
        return -1;
    endfunction

    // Model: expected outputs k cycles after the capturing edge.
    function automatic void model_cycle(input logic [15:0] a, input logic r, input int k,
                                        output logic [7:0] e_sel, output logic [7:0] e_rd,
                                        output logic [7:0] e_wr, output logic e_rdy,
                                        output logic e_unm);
        int reg_i;
        int ws;
        reg_i = model_region(a);
        e_sel = '0; e_rd = '0; e_wr = '0; e_rdy = 1'b1; e_unm = 1'b0;
        if (reg_i < 0) begin
            e_unm = (k == 1);
        end else begin
            ws = int'(TB_WS[reg_i]);
            if (k <= ws + 1) e_sel = 8'(1 << reg_i);
            if (k <= ws) e_rdy = 1'b0;
            if (k == ws + 1) begin
                if (r) e_rd = 8'(1 << reg_i);
                else   e_wr = 8'(1 << reg_i);
            end
        end
    endfunction

    // Issue one access and record n cycles of outputs; optionally raise a
    // stray phi2_en during cycle extra_k.
    task automatic drive_access(input logic [15:0] a, input logic r, input int n, input int extra_k);
        addr = a; rw = r; valid = 1'b1; phi2_en = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            phi2_en = 1'b0; valid = 1'b0;
            o_sel[k] = sel; o_rd[k] = rd_stb; o_wr[k] = wr_stb;
            o_rdy[k] = ready; o_unm[k] = unmapped;
            if (k == extra_k) begin
                phi2_en = 1'b1; valid = 1'b1; addr = 16'h2000;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sel !== 8'h00) begin n_fail++; $display("FAIL reset sel: got %h expected 00", sel); end
        n_checks++; if (rd_stb !== 8'h00 || wr_stb !== 8'h00) begin n_fail++; $display("FAIL reset strobes: got rd=%h wr=%h expected 00", rd_stb, wr_stb); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b expected 1", ready); end
        n_checks++; if (unmapped !== 1'b0 || wdog_reset !== 1'b0) begin n_fail++; $display("FAIL reset pulses: got unm=%b wdog=%b expected 0", unmapped, wdog_reset); end
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset state: got %0d expected IDLE", dut.state); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ws0_read();
        drive_access(16'h2345, 1'b1, 3, 0);
        n_checks++; if (o_sel[1] !== 8'h04) begin n_fail++; $display("FAIL ws0 sel T+1: got %h expected 04", o_sel[1]); end
        n_checks++; if (o_rd[1] !== 8'h04 || o_wr[1] !== 8'h00) begin n_fail++; $display("FAIL ws0 strobe T+1: got rd=%h wr=%h expected rd=04 wr=00", o_rd[1], o_wr[1]); end
        n_checks++; if (o_sel[2] !== 8'h00 || o_rd[2] !== 8'h00) begin n_fail++; $display("FAIL ws0 T+2: got sel=%h rd=%h expected 00", o_sel[2], o_rd[2]); end
        n_checks++; if (!(o_rdy[1] && o_rdy[2] && o_rdy[3])) begin n_fail++; $display("FAIL ws0 ready: got %b%b%b expected 111", o_rdy[1], o_rdy[2], o_rdy[3]); end
    endtask

    task automatic test_ws3_write();
        drive_access(16'h3abc, 1'b0, 7, 2);
        for (int k = 1; k <= 3; k++) begin
            n_checks++; if (o_rdy[k] !== 1'b0) begin n_fail++; $display("FAIL ws3 ready T+%0d: got %b expected 0", k, o_rdy[k]); end
            n_checks++; if (o_wr[k] !== 8'h00 || o_sel[k] !== 8'h08) begin n_fail++; $display("FAIL ws3 T+%0d: got sel=%h wr=%h expected sel=08 wr=00", k, o_sel[k], o_wr[k]); end
        end
        n_checks++; if (o_wr[4] !== 8'h08 || o_rd[4] !== 8'h00 || o_rdy[4] !== 1'b1) begin n_fail++; $display("FAIL ws3 strobe T+4: got wr=%h rd=%h rdy=%b expected wr=08 rd=00 rdy=1", o_wr[4], o_rd[4], o_rdy[4]); end
        n_checks++; if (o_sel[4] !== 8'h08 || o_sel[5] !== 8'h00) begin n_fail++; $display("FAIL ws3 sel fall: got T+4=%h T+5=%h expected 08 00", o_sel[4], o_sel[5]); end
        for (int k = 5; k <= 7; k++) begin
            n_checks++; if (o_sel[k] !== 8'h00 || o_rd[k] !== 8'h00 || o_wr[k] !== 8'h00) begin n_fail++; $display("FAIL ws3 stray phi2 T+%0d: got sel=%h rd=%h wr=%h expected 00", k, o_sel[k], o_rd[k], o_wr[k]); end
        end
    endtask

    task automatic test_overlap();
        drive_access(16'h0100, 1'b1, 4, 0);
        n_checks++; if (o_sel[1] !== 8'h01 || o_sel[2] !== 8'h01) begin n_fail++; $display("FAIL overlap sel: got %h %h expected 01 01", o_sel[1], o_sel[2]); end
        n_checks++; if (o_rd[2] !== 8'h01 || o_wr[2] !== 8'h00 || o_rd[1] !== 8'h00) begin n_fail++; $display("FAIL overlap strobe: got rd1=%h rd2=%h wr2=%h expected 00 01 00", o_rd[1], o_rd[2], o_wr[2]); end
    endtask

    task automatic test_unmapped();
        drive_access(16'h4abc, 1'b0, 3, 0);
        n_checks++; if (o_unm[1] !== 1'b1 || o_unm[2] !== 1'b0) begin n_fail++; $display("FAIL unmapped pulse: got %b%b expected 10", o_unm[1], o_unm[2]); end
        for (int k = 1; k <= 3; k++) begin
            n_checks++; if (o_sel[k] !== 8'h00 || o_rd[k] !== 8'h00 || o_wr[k] !== 8'h00 || o_rdy[k] !== 1'b1) begin n_fail++; $display("FAIL unmapped T+%0d: got sel=%h rd=%h wr=%h rdy=%b expected 00 00 00 1", k, o_sel[k], o_rd[k], o_wr[k], o_rdy[k]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        r;
        logic [7:0]  e_sel, e_rd, e_wr;
        logic        e_rdy, e_unm;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            r = 1'($urandom);
            drive_access(a, r, 10, 0);
            for (int k = 1; k <= 10; k++) begin
                model_cycle(a, r, k, e_sel, e_rd, e_wr, e_rdy, e_unm);
                n_checks++;
                if (o_sel[k] !== e_sel || o_rd[k] !== e_rd || o_wr[k] !== e_wr ||
                    o_rdy[k] !== e_rdy || o_unm[k] !== e_unm) begin
                    n_fail++;
                    $display("FAIL random a=%h rw=%b T+%0d: got sel=%h rd=%h wr=%h rdy=%b unm=%b expected sel=%h rd=%h wr=%h rdy=%b unm=%b",
                             a, r, k, o_sel[k], o_rd[k], o_wr[k], o_rdy[k], o_unm[k], e_sel, e_rd, e_wr, e_rdy, e_unm);
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wdog();
        int pulses;
        pulses = 0;
        for (int t = 1; t <= 4; t++) begin
            frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
            n_checks++; if (wdog_reset !== (t == 4)) begin n_fail++; $display("FAIL wdog tick %0d: got %b expected %b", t, wdog_reset, (t == 4)); end
            if (wdog_reset) pulses++;
            @(posedge clk); #1;
            if (wdog_reset) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL wdog pulse count: got %0d expected 1", pulses); end
        // Three ticks, then a region-1 write whose strobe lands on the 4th tick.
        for (int t = 1; t <= 3; t++) begin
            frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
            @(posedge clk); #1;
        end
        addr = 16'h1000; rw = 1'b0; valid = 1'b1; phi2_en = 1'b1;
        @(posedge clk); #1;
        phi2_en = 1'b0; valid = 1'b0; frame_tick = 1'b1;
        n_checks++; if (wr_stb !== 8'h02) begin n_fail++; $display("FAIL wdog kick strobe: got %h expected 02", wr_stb); end
        @(posedge clk); #1; frame_tick = 1'b0;
        n_checks++; if (wdog_reset !== 1'b0) begin n_fail++; $display("FAIL wdog kick wins: got %b expected 0", wdog_reset); end
        n_checks++; if (dut.wdog_cnt !== 8'd0) begin n_fail++; $display("FAIL wdog cnt after kick: got %0d expected 0", dut.wdog_cnt); end
        for (int t = 1; t <= 4; t++) begin
            frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
            n_checks++; if (wdog_reset !== (t == 4)) begin n_fail++; $display("FAIL wdog post-kick tick %0d: got %b expected %b", t, wdog_reset, (t == 4)); end
            @(posedge clk); #1;
        end
        // A read of the watchdog region must not reset the count.
        for (int t = 1; t <= 3; t++) begin
            frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
            @(posedge clk); #1;
        end
        drive_access(16'h1000, 1'b1, 3, 0);
        frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
        n_checks++; if (wdog_reset !== 1'b1) begin n_fail++; $display("FAIL wdog read no kick: got %b expected 1", wdog_reset); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid();
        int strobes;
        strobes = 0;
        addr = 16'h5123; rw = 1'b0; valid = 1'b1; phi2_en = 1'b1;
        @(posedge clk); #1; phi2_en = 1'b0; valid = 1'b0;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst-mid in wait: got ready=%b expected 0", ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (dut.state !== ST_IDLE || ready !== 1'b1 || sel !== 8'h00) begin n_fail++; $display("FAIL rst-mid abort: got state=%0d ready=%b sel=%h expected IDLE 1 00", dut.state, ready, sel); end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rd_stb !== 8'h00 || wr_stb !== 8'h00 || sel !== 8'h00) strobes++;
            @(posedge clk); #1;
        end
        n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL rst-mid late strobe: got %0d active cycles expected 0", strobes); end
    endtask

    initial begin
        test_reset();
        test_ws0_read();
        test_ws3_write();
        test_overlap();
        test_unmapped();
        test_random();
        test_wdog();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
